// File: rtl/reg_and_not_reg_input_mul_with_accum_pkg.sv
// Shared widths, signed operand/accumulator types and the accumulate step
// used by the multiply-accumulate datapath.
package reg_and_not_reg_input_mul_with_accum_pkg;

   localparam int A_W = 20;
   localparam int B_W = 18;
   localparam int P_W = 38;

   typedef logic signed [A_W-1:0] op_a_t;
   typedef logic signed [B_W-1:0] op_b_t;
   typedef logic signed [P_W-1:0] acc_t;

   // One accumulate step; plain modular arithmetic, so overflow wraps.
   function automatic acc_t accum_step(input acc_t acc, input acc_t prod, input logic sub);
      return sub ? (acc - prod) : (acc + prod);
   endfunction

endpackage

// File: rtl/reg_and_not_reg_input_mul_with_accum_mul_accum_core.sv
// Signed multiply followed by an add/subtract accumulator register.
module mul_accum_core
   import reg_and_not_reg_input_mul_with_accum_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  subtract_i,
   input  op_a_t a,
   input  op_b_t b,
   output acc_t  p
);

   acc_t product;

   // Operands are sign-extended to the full width first so nothing is lost.
   assign product = acc_t'(a) * acc_t'(b);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p <= '0;
      end else begin
         p <= accum_step(p, product, subtract_i);
      end
   end

endmodule

// File: rtl/reg_and_not_reg_input_mul_with_accum.sv
// Multiply-accumulate with a registered A operand and a direct B operand.
module reg_and_not_reg_input_mul_with_accum
   import reg_and_not_reg_input_mul_with_accum_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           subtract_i,
   input  logic [A_W-1:0] A,
   input  logic [B_W-1:0] B,
   output logic [P_W-1:0] P
);

   op_a_t a_q;
   acc_t  p_acc;

   // A takes one extra cycle to reach the multiplier; B does not.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q <= '0;
      end else begin
         a_q <= op_a_t'(A);
      end
   end

   mul_accum_core u_core (
      .clk        (clk),
      .reset      (reset),
      .subtract_i (subtract_i),
      .a          (a_q),
      .b          (op_b_t'(B)),
      .p          (p_acc)
   );

   assign P = p_acc;

endmodule

// File: tb/tb_reg_and_not_reg_input_mul_with_accum.sv
// Self-checking bench: directed cases plus randomized stimulus against a
// behavioural model of the delayed-A multiply-accumulate.
module tb_reg_and_not_reg_input_mul_with_accum;

   logic               clk = 1'b0;
   logic               reset;
   logic               subtract_i;
   logic signed [19:0] A;
   logic signed [17:0] B;
   logic        [37:0] P;

   int checks_total  = 0;
   int checks_passed = 0;

   // Reference state: the previous cycle's A and the wrapped 38-bit sum.
   longint             model_aq = 0;
   logic signed [37:0] model_p  = '0;

   reg_and_not_reg_input_mul_with_accum dut (
      .clk        (clk),
      .reset      (reset),
      .subtract_i (subtract_i),
      .A          (A),
      .B          (B),
      .P          (P)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [37:0] got, input logic [37:0] expv);
      checks_total++;
      if (got === expv) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(expv));
      end
   endtask

   // Drive inputs just after a falling edge, clock once, advance the model,
   // and return at the next falling edge ready for sampling.
   task automatic applyStimulus(input logic signed [19:0] a_v, input logic signed [17:0] b_v,
                                input logic sub_v);
      longint prod;
      longint sum;
      A          = a_v;
      B          = b_v;
      subtract_i = sub_v;
      @(posedge clk);
      if (reset) begin
         prod = model_aq * longint'(b_v);
         sum  = sub_v ? (longint'(model_p) - prod) : (longint'(model_p) + prod);
         model_p  = sum[37:0];
         model_aq = longint'(a_v);
      end
      @(negedge clk);
   endtask

   // Assert reset between edges, confirm P clears without a clock edge,
   // hold it across one edge and release at a falling edge.
   task automatic pulseReset(input string tag);
      #2 reset = 1'b0;
      #1 checkOutput(tag, P, 38'd0);
      model_aq = 0;
      model_p  = '0;
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_held"}, P, 38'd0);
      reset = 1'b1;
   endtask

   initial begin
      reset      = 1'b0;
      subtract_i = 1'b0;
      A          = 20'sd7;
      B          = 18'sd3;
      #1 checkOutput("reset_t1", P, 38'd0);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("reset_hold", P, 38'd0);
      end
      reset = 1'b1;

      // Add: a_q is still 0 at the first edge.
      applyStimulus(20'sd5, 18'sd2, 1'b0);
      checkOutput("add_e1", P, 38'd0);
      applyStimulus(20'sd5, 18'sd2, 1'b0);
      checkOutput("add_e2", P, 38'd10);
      applyStimulus(20'sd5, 18'sd2, 1'b0);
      checkOutput("add_e3", P, 38'd20);

      // B reaches the multiplier without a register stage.
      applyStimulus(20'sd5, 18'sd3, 1'b0);
      checkOutput("b_direct", P, 38'd35);

      pulseReset("reset_mid");

      applyStimulus(20'sd5, 18'sd2, 1'b1);
      checkOutput("sub_e1", P, 38'd0);
      applyStimulus(20'sd5, 18'sd2, 1'b1);
      checkOutput("sub_e2", P, -38'sd10);
      applyStimulus(20'sd5, 18'sd2, 1'b1);
      checkOutput("sub_e3", P, -38'sd20);

      pulseReset("reset_wrap");

      applyStimulus(-20'sd524288, -18'sd131072, 1'b0);
      checkOutput("wrap_e1", P, 38'd0);
      applyStimulus(-20'sd524288, -18'sd131072, 1'b0);
      checkOutput("wrap_e2", P, 38'h10_0000_0000);
      applyStimulus(-20'sd524288, -18'sd131072, 1'b0);
      checkOutput("wrap_e3", P, 38'h20_0000_0000);
      applyStimulus(-20'sd524288, -18'sd131072, 1'b0);
      checkOutput("wrap_e4", P, 38'h30_0000_0000);

      pulseReset("reset_rand");

      for (int i = 0; i < 32; i++) begin
         if (i == 16) begin
            pulseReset("reset_rand_mid");
         end
         applyStimulus(20'($urandom), 18'($urandom), 1'($urandom));
         checkOutput($sformatf("rand_%0d", i), P, model_p);
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/reg_and_not_reg_input_mul_with_accum.md
REG_AND_NOT_REG_INPUT_MUL_WITH_ACCUM -- requirements
Module: reg_and_not_reg_input_mul_with_accum

Interface
REQ-001 Parameters: none; widths fixed (A_W=20, B_W=18, P_W=38) as package constants.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = asserted).
REQ-004 subtract_i  input  1  accumulate mode: 0 = P + product, 1 = P - product.
REQ-005 A  input  20  signed two's-complement multiplicand; registered input path.
REQ-006 B  input  18  signed two's-complement multiplier; unregistered (direct) input path.
REQ-007 P  output  38  signed accumulator value; driven directly from the accumulator register.
REQ-008 Port order: clk, reset, subtract_i, A, B, P.

Function
REQ-009 Input register a_q (20 bits, signed) SHALL load A on every rising clk edge when reset is deasserted.
REQ-010 Product SHALL be the full-precision signed product a_q * B, 38 bits, no truncation or rounding.
REQ-011 On every rising edge with reset deasserted: P <= P + product (subtract_i=0), or P <= P - product (subtract_i=1).
REQ-012 subtract_i SHALL NOT be registered; its value at the same edge selects add/subtract.
REQ-013 Latency: A change -> first contribution to P at the 2nd rising edge; B change -> first contribution at the next rising edge.
REQ-014 Constant A, B: P changes by exactly +/-(A*B) per clock from the 2nd edge onward.
REQ-015 Accumulator arithmetic: 38-bit two's complement, wraps on overflow/underflow; no saturation, no overflow flag.
REQ-016 No enable or clear input; accumulation occurs every cycle. A=0 or B=0 holds P.
REQ-017 Switching subtract_i mid-stream SHALL take effect at the next edge with no pipeline flush.

Reset
REQ-018 reset=0 SHALL clear a_q and P to 0 immediately, independent of clk.
REQ-019 P SHALL hold 0 while reset=0, regardless of A, B, subtract_i.
REQ-020 After release, the first edge accumulates a_q(=0)*B = 0; the first nonzero contribution comes at the 2nd edge.
REQ-021 Reset assertion mid-accumulation SHALL discard all state; no partial value is retained.

Structure
REQ-022 Shared package: width constants A_W, B_W, P_W, and signed typedefs for operand A, operand B, and accumulator.
REQ-023 Optional single sub-module mul_accum_core (signed multiply plus add/subtract accumulator register); the A input register stays in the top module.
REQ-024 Purely synchronous datapath apart from the async reset; no latches; no clock gating.

Verification
REQ-025 Reset: drive reset=0 for 2 cycles with A=7, B=3 -> P=0 throughout; P goes to 0 asynchronously, before any clock edge.
REQ-026 Add: from P=0, subtract_i=0, set A=5, B=2 after a falling edge -> P=0 after edge 1, P=10 after edge 2, P=20 after edge 3.
REQ-027 Subtract: from P=0, subtract_i=1, A=5, B=2 -> P=-10 after edge 2, P=-20 after edge 3.
REQ-028 Unregistered B: with a_q=5, change B from 2 to 3 -> the very next edge adds 15.
REQ-029 Wrap: A=-524288, B=-131072 (product 2^36), add mode -> P=2^36, then -2^37 (wrap), then -2^36.
REQ-030 Random: 32 cycles of random signed A, B, subtract_i against a reference model with one-cycle A delay -> zero mismatches. Reset is asserted mid-run; P=0 immediately, and the model resyncs.
